// File: rtl/job_seq_pkg.sv
// Shared types and defaults for the job sequencer front-end.
package job_seq_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  localparam int DATA_W_DEF  = 8;
  localparam int RES_W_DEF   = 16;
  localparam int DEPTH_DEF   = 4;
  localparam int TIMEOUT_DEF = 255;

  // A disabled watchdog still gets a 1-bit counter so no zero-width vector appears.
  function automatic int wd_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction
endpackage

// File: rtl/job_sequencer_if.sv
// Host and datapath-controller signals of the job sequencer.
interface job_sequencer_if
  import job_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RES_W  = RES_W_DEF
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              start;
  logic              done;
  logic [DATA_W-1:0] dp_operand;
  logic [RES_W-1:0]  dp_result;
  logic              out_valid;
  logic [RES_W-1:0]  out_data;
  logic              out_ready;
  logic              busy;
  logic              timeout_err;

  modport slave (
    input  in_valid, in_data, done, dp_result, out_ready,
    output in_ready, start, dp_operand, out_valid, out_data, busy, timeout_err
  );
  modport master (
    output in_valid, in_data, done, dp_result, out_ready,
    input  in_ready, start, dp_operand, out_valid, out_data, busy, timeout_err
  );
endinterface

// File: rtl/job_sequencer_sync_fifo.sv
// Operand buffer: pointer-with-wrap-bit FIFO, no read bypass.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Same index with differing wrap bits means the write side has lapped the read side.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/job_sequencer.sv
// Buffers host operands, launches one datapath job at a time, returns results, guards with a watchdog.
module job_sequencer
  import job_seq_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RES_W   = RES_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic            clk,
  input logic            rst,
  job_sequencer_if.slave bus
);
  localparam int WD_W = wd_width(TIMEOUT);

  state_t            state, state_nxt;
  logic              push, pop, full, empty;
  logic              slot_free, expire, capture, abandon;
  logic [DATA_W-1:0] head, operand;
  logic [RES_W-1:0]  res_data;
  logic              res_valid, err;
  logic [WD_W-1:0]   wd;

  assign push = bus.in_valid & ~full;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (bus.in_data),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // A launch needs the result slot empty or draining, so a capture never finds it occupied.
  assign slot_free = ~res_valid | bus.out_ready;
  assign expire    = (TIMEOUT != 0) && (wd == WD_W'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    abandon   = 1'b0;
    case (state)
      IDLE: if (!empty && slot_free) begin
        pop       = 1'b1;
        state_nxt = LAUNCH;
      end
      LAUNCH: state_nxt = WAIT;
      WAIT: begin
        if (bus.done) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end else if (expire) begin
          abandon   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      operand   <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      err       <= 1'b0;
      wd        <= '0;
    end else begin
      if (pop) operand <= head;
      if (state == LAUNCH)    wd <= '0;
      else if (state == WAIT) wd <= wd + 1'b1;
      if (capture) begin
        res_data  <= bus.dp_result;
        res_valid <= 1'b1;
      end else if (res_valid && bus.out_ready) begin
        res_valid <= 1'b0;
      end
      if (abandon) err <= 1'b1;
    end
  end

  assign bus.in_ready    = ~full;
  assign bus.start       = (state == LAUNCH);
  assign bus.busy        = (state == LAUNCH) || (state == WAIT);
  assign bus.dp_operand  = operand;
  assign bus.out_valid   = res_valid;
  assign bus.out_data    = res_data;
  assign bus.timeout_err = err;
endmodule

// File: tb/tb_job_sequencer.sv
// Randomized and directed bench for job_sequencer against a queue-based job model.
module tb_job_sequencer;
  import job_seq_pkg::*;

  localparam int DW = 8, RW = 16, DEPTH = 4, TO = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  job_sequencer_if #(.DATA_W(DW), .RES_W(RW)) bus();
  job_sequencer #(.DATA_W(DW), .RES_W(RW), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0, n_bad = 0;
  // stimulus knobs
  logic          iv = 1'b0, orr = 1'b0;
  logic [DW-1:0] id = '0;
  int            ctrl_lat = 3, ctrl_cnt = 0;
  bit            use_fix = 1'b0, spur = 1'b0, sb_on = 1'b0, b2b = 1'b0;
  logic [RW-1:0] fixv = '0;
  // bookkeeping
  int cyc = 0, last_start = -10, last_cap = -10, n_start = 0, n_start_phase = 0, n_drain = 0;
  // job model: queue of operands, job age (-1 none, 0 launch cycle, k = k-th cycle after start)
  logic [DW-1:0] mq[$], exp_q[$];
  int            age = -1;
  logic [DW-1:0] m_op = '0;
  logic [RW-1:0] m_res = '0;
  bit            m_has = 1'b0, m_err = 1'b0;

  function automatic logic [RW-1:0] resf(input logic [DW-1:0] o);
    return {o ^ 8'hA5, o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete(); exp_q.delete();
    age = -1; m_op = '0; m_res = '0; m_has = 0; m_err = 0; ctrl_cnt = 0;
  endtask

  task automatic model_step(input logic iv_, input logic [DW-1:0] id_, input logic or_,
                            input logic dn_, input logic [RW-1:0] dr_);
    bit pushed, launch, drain;
    pushed = iv_ && (mq.size() < DEPTH);
    launch = (age < 0) && (mq.size() > 0) && (!m_has || or_);
    drain  = m_has && or_;
    if (drain) begin
      m_has = 0;
      n_drain++;
      if (sb_on) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_underflow: result %0h with no operand outstanding", bus.out_data);
        end else chk("sb_order", bus.out_data, resf(exp_q.pop_front()));
      end
    end
    if (launch) begin
      m_op = mq.pop_front();
      age  = 0;
    end else if (age == 0) begin
      age = 1;
    end else if (age > 0) begin
      if (dn_) begin
        m_has = 1; m_res = dr_; age = -1; last_cap = cyc;
      end else if (TO != 0 && age == TO + 1) begin
        m_err = 1; age = -1;
      end else age++;
    end
    if (pushed) begin
      mq.push_back(id_);
      if (sb_on) exp_q.push_back(id_);
    end
  endtask

  task automatic step();
    logic          dn;
    logic [RW-1:0] dr;
    @(posedge clk); #1;
    cyc++;
    dn = spur || (ctrl_cnt == 1);
    if (ctrl_cnt > 0) ctrl_cnt--;
    dr = use_fix ? fixv : resf(bus.dp_operand);
    bus.in_valid = iv; bus.in_data = id; bus.out_ready = orr;
    bus.done = dn; bus.dp_result = dr;
    #1;
    chk("in_ready",    bus.in_ready,    mq.size() < DEPTH);
    chk("start",       bus.start,       age == 0);
    chk("busy",        bus.busy,        age >= 0);
    chk("dp_operand",  bus.dp_operand,  m_op);
    chk("out_valid",   bus.out_valid,   m_has);
    chk("timeout_err", bus.timeout_err, m_err);
    if (m_has) chk("out_data", bus.out_data, m_res);
    if (bus.start) begin
      chk("start_adjacent", last_start == cyc - 1, 0);
      if (b2b && n_start_phase > 0) chk("b2b_gap", cyc - last_cap, 2);
      n_start++; n_start_phase++;
      last_start = cyc;
      ctrl_cnt   = ctrl_lat;
    end
    model_step(iv, id, orr, dn, dr);
    spur = 0;
  endtask

  task automatic drain_idle(input string tag);
    iv = 0; orr = 1; spur = 0; ctrl_lat = 3;
    for (int k = 0; k < 300; k++) begin
      if (!bus.busy && !bus.out_valid && mq.size() == 0 && age < 0) break;
      step();
    end
    chk(tag, !bus.busy && !bus.out_valid && mq.size() == 0, 1);
    ctrl_cnt = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int s1, pc, nst0, nd0;
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0; bus.done = 0; bus.dp_result = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_in_ready",   bus.in_ready, 1);
    chk("rst_start",      bus.start, 0);
    chk("rst_busy",       bus.busy, 0);
    chk("rst_out_valid",  bus.out_valid, 0);
    chk("rst_out_data",   bus.out_data, 0);
    chk("rst_dp_operand", bus.dp_operand, 0);
    chk("rst_timeout",    bus.timeout_err, 0);

    // single job, 6-cycle datapath
    orr = 0; use_fix = 1; fixv = 16'h1234; ctrl_lat = 6;
    iv = 1; id = 8'h2A; step(); pc = cyc; iv = 0;
    for (int k = 0; k < 30; k++) begin if (bus.out_valid) break; step(); end
    chk("t1_start_lat",  last_start - pc, 2);
    chk("t1_nstart",     n_start, 1);
    chk("t1_result_lat", cyc - last_start, 7);
    chk("t1_data",       bus.out_data, 16'h1234);
    chk("t1_operand",    bus.dp_operand, 8'h2A);
    orr = 1; step(); orr = 0; step();

    // spurious done while idle
    fixv = 16'hFFFF; spur = 1; step(); step();
    chk("t4_spurious", bus.out_valid, 0);
    use_fix = 0;

    // backpressure: five operands, result slot held
    sb_on = 1; exp_q.delete(); orr = 0; ctrl_lat = 3; nst0 = n_start;
    for (int k = 0; k < 5; k++) begin iv = 1; id = 8'($urandom); step(); end
    iv = 0; step();
    chk("t2_in_ready_low", bus.in_ready, 0);
    repeat (18) step();
    chk("t2_one_start", n_start - nst0, 1);
    chk("t2_still_full", bus.in_ready, 0);
    orr = 1; nd0 = n_drain;
    for (int k = 0; k < 100; k++) begin if (n_drain - nd0 == 5) break; step(); end
    chk("t2_drained", n_drain - nd0, 5);
    drain_idle("t2_idle");

    // back-to-back with constant out_ready
    b2b = 1; n_start_phase = 0; nd0 = n_drain; orr = 1;
    for (int k = 0; k < 4; k++) begin
      iv = 1; id = 8'($urandom); ctrl_lat = $urandom_range(1, 5); step();
    end
    iv = 0;
    for (int k = 0; k < 100; k++) begin
      if (n_drain - nd0 == 4) break;
      ctrl_lat = $urandom_range(1, 5); step();
    end
    chk("t6_results", n_drain - nd0, 4);
    chk("t6_starts", n_start_phase, 4);
    b2b = 0;

    // random traffic, every job finishes inside the watchdog window
    for (int k = 0; k < 1500; k++) begin
      iv = 1'($urandom_range(0, 1)); id = 8'($urandom);
      orr = ($urandom_range(0, 9) < 7); ctrl_lat = $urandom_range(1, 11);
      spur = ($urandom_range(0, 19) == 0);
      step();
    end
    drain_idle("randA_idle");
    sb_on = 0;

    // watchdog expiry, then the queued job runs normally
    chk("t3_err_before", bus.timeout_err, 0);
    orr = 1; ctrl_lat = 0;
    iv = 1; id = 8'h11; step(); id = 8'h22; step(); iv = 0;
    for (int k = 0; k < 40; k++) begin if (bus.timeout_err) break; step(); end
    chk("t3_err_delay", cyc - last_start, 12);
    chk("t3_no_result", bus.out_valid, 0);
    s1 = last_start; ctrl_lat = 4;
    for (int k = 0; k < 5; k++) begin if (last_start != s1) break; step(); end
    chk("t3_relaunch", last_start - s1, 13);
    for (int k = 0; k < 20; k++) begin if (bus.out_valid) break; step(); end
    chk("t3_second_result", bus.out_data, 16'h8722);

    // random traffic including timeouts and late dones
    for (int k = 0; k < 800; k++) begin
      iv = 1'($urandom_range(0, 1)); id = 8'($urandom);
      orr = ($urandom_range(0, 9) < 7); ctrl_lat = $urandom_range(1, 14);
      spur = ($urandom_range(0, 19) == 0);
      step();
    end
    drain_idle("randB_idle");

    // async reset in WAIT with three operands buffered
    orr = 1; ctrl_lat = 0;
    for (int k = 0; k < 4; k++) begin iv = 1; id = 8'(8'h40 + k); step(); end
    iv = 0;
    for (int k = 0; k < 20; k++) begin if (bus.busy && !bus.start) break; step(); end
    step(); step();
    chk("t5_buffered", mq.size(), 3);
    chk("t5_in_wait", bus.busy && !bus.start, 1);
    #1 rst = 1'b1;
    #1;
    chk("t5_start",     bus.start, 0);
    chk("t5_busy",      bus.busy, 0);
    chk("t5_out_valid", bus.out_valid, 0);
    chk("t5_out_data",  bus.out_data, 0);
    chk("t5_operand",   bus.dp_operand, 0);
    chk("t5_timeout",   bus.timeout_err, 0);
    chk("t5_in_ready",  bus.in_ready, 1);
    model_reset();
    #1 rst = 1'b0;
    use_fix = 1; fixv = 16'hFFFF; spur = 1; step(); step();
    chk("t5_stale_done", bus.out_valid, 0);
    use_fix = 0; ctrl_lat = 3;
    iv = 1; id = 8'h05; step(); iv = 0;
    for (int k = 0; k < 20; k++) begin if (bus.out_valid) break; step(); end
    chk("t5_fresh_valid", bus.out_valid, 1);
    chk("t5_fresh_data",  bus.out_data, 16'hA005);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
